// File: rtl/pc_fetch.sv
// Program counter and instruction fetch for the single-cycle core, plus the
// synchroniser/debouncer that turns the raw sw8 slide switch into a clean level.
module pc_fetch #(
   parameter int PSIZE      = 5,
   parameter int ISIZE      = 16,
   parameter int PROG_LAST  = 31,
   parameter int DEB_CYCLES = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               PCincr,
   input  logic               sw8_raw,
   input  logic [ISIZE-1:0]   rom_data,
   output logic [PSIZE-1:0]   rom_addr,
   output logic [PSIZE-1:0]   pc,
   output logic [4:0]         opcode,
   output logic [ISIZE-6:0]   operand,
   output logic               sw8
);

   localparam int DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

   logic [PSIZE-1:0] pc_q, pc_d;
   logic             sync1_q, sync2_q;
   logic [DW-1:0]    deb_cnt_q, deb_cnt_d;
   logic             sw8_q, sw8_d;

   // >= rather than == so an out-of-range pc still wraps back to 0
   always_comb begin
      pc_d = pc_q;
      if (PCincr) begin
         if (pc_q >= PSIZE'(PROG_LAST)) pc_d = '0;
         else                          pc_d = pc_q + PSIZE'(1);
      end
   end

   always_comb begin
      deb_cnt_d = deb_cnt_q;
      sw8_d     = sw8_q;
      if (sync2_q == sw8_q) begin
         deb_cnt_d = '0;
      end else if (deb_cnt_q == DW'(DEB_CYCLES - 1)) begin
         sw8_d     = sync2_q;
         deb_cnt_d = '0;
      end else begin
         deb_cnt_d = deb_cnt_q + DW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q      <= '0;
         sync1_q   <= 1'b0;
         sync2_q   <= 1'b0;
         deb_cnt_q <= '0;
         sw8_q     <= 1'b0;
      end else begin
         pc_q      <= pc_d;
         sync1_q   <= sw8_raw;
         sync2_q   <= sync1_q;
         deb_cnt_q <= deb_cnt_d;
         sw8_q     <= sw8_d;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) assert (!$isunknown(PCincr));
   end

   assign pc       = pc_q;
   assign rom_addr = pc_q;
   assign opcode   = rom_data[ISIZE-1:ISIZE-5];
   assign operand  = rom_data[ISIZE-6:0];
   assign sw8      = sw8_q;

endmodule
